// File: rtl/reservation_station_if.sv
// Dispatch / CDB / issue bus of the reservation station.
// master: rename/dispatch, writeback and FU side; slave: the reservation station.
interface reservation_station_if #(
   parameter int TAG_W = 6,
   parameter int OP_W  = 32
);
   logic             flush;
   logic             disp_valid;
   logic             disp_ready;
   logic [OP_W-1:0]  disp_op;
   logic [TAG_W-1:0] disp_rd_tag;
   logic [TAG_W-1:0] disp_rs1_tag;
   logic [TAG_W-1:0] disp_rs2_tag;
   logic             disp_rs1_rdy;
   logic             disp_rs2_rdy;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic             issue_valid;
   logic             issue_ready;
   logic [OP_W-1:0]  issue_op;
   logic [TAG_W-1:0] issue_rd_tag;
   logic [TAG_W-1:0] issue_rs1_tag;
   logic [TAG_W-1:0] issue_rs2_tag;

   modport master (
      output flush, disp_valid, disp_op, disp_rd_tag, disp_rs1_tag, disp_rs2_tag,
             disp_rs1_rdy, disp_rs2_rdy, cdb_valid, cdb_tag, issue_ready,
      input  disp_ready, issue_valid, issue_op, issue_rd_tag, issue_rs1_tag, issue_rs2_tag
   );

   modport slave (
      input  flush, disp_valid, disp_op, disp_rd_tag, disp_rs1_tag, disp_rs2_tag,
             disp_rs1_rdy, disp_rs2_rdy, cdb_valid, cdb_tag, issue_ready,
      output disp_ready, issue_valid, issue_op, issue_rd_tag, issue_rs1_tag, issue_rs2_tag
   );
endinterface

// File: rtl/reservation_station.sv
// Unified issue queue: holds DEPTH renamed micro-ops, wakes sources on CDB
// broadcasts and presents the highest-index ready entry to the functional unit.
// Allocation also picks the highest-index free entry; there is no age ordering.
// Optional feature: define RS_OCC_COUNT_EN to add the registered occupancy port.
module reservation_station #(
   parameter int DEPTH = 8,
   parameter int TAG_W = 6,
   parameter int OP_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   reservation_station_if.slave     rs
`ifdef RS_OCC_COUNT_EN
   ,
   output logic [$clog2(DEPTH):0]   occupancy
`endif
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
   logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
   logic [OP_W-1:0]  op_q      [DEPTH];
   logic [OP_W-1:0]  op_d      [DEPTH];
   logic [TAG_W-1:0] rd_tag_q  [DEPTH];
   logic [TAG_W-1:0] rd_tag_d  [DEPTH];
   logic [TAG_W-1:0] rs1_tag_q [DEPTH];
   logic [TAG_W-1:0] rs1_tag_d [DEPTH];
   logic [TAG_W-1:0] rs2_tag_q [DEPTH];
   logic [TAG_W-1:0] rs2_tag_d [DEPTH];

   logic [DEPTH-1:0] req;
   logic [IDX_W-1:0] alloc_idx;
   logic [IDX_W-1:0] issue_idx;
   logic             disp_ready;
   logic             issue_valid;
   logic             disp_fire;
   logic             issue_fire;

   // Highest-set-bit selection for allocation (free entries) and issue (ready entries)
   always_comb begin
      req       = valid_q & rs1_rdy_q & rs2_rdy_q;
      alloc_idx = '0;
      issue_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i]) alloc_idx = IDX_W'(i);
         if (req[i])      issue_idx = IDX_W'(i);
      end
   end

   // disp_ready looks only at registered state, so a slot freed by this cycle's issue waits a cycle
   assign disp_ready  = ~&valid_q;
   assign issue_valid = (|req) & ~rs.flush;
   assign disp_fire   = rs.disp_valid & disp_ready & ~rs.flush;
   assign issue_fire  = issue_valid & rs.issue_ready;

   assign rs.disp_ready    = disp_ready;
   assign rs.issue_valid   = issue_valid;
   assign rs.issue_op      = op_q[issue_idx];
   assign rs.issue_rd_tag  = rd_tag_q[issue_idx];
   assign rs.issue_rs1_tag = rs1_tag_q[issue_idx];
   assign rs.issue_rs2_tag = rs2_tag_q[issue_idx];

   // Next entry state: wakeup, issue retire, dispatch write (with CDB bypass); flush wins
   always_comb begin
      valid_d   = valid_q;
      rs1_rdy_d = rs1_rdy_q;
      rs2_rdy_d = rs2_rdy_q;
      op_d      = op_q;
      rd_tag_d  = rd_tag_q;
      rs1_tag_d = rs1_tag_q;
      rs2_tag_d = rs2_tag_q;
      if (rs.cdb_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rs1_tag_q[i] == rs.cdb_tag) rs1_rdy_d[i] = 1'b1;
            if (valid_q[i] && rs2_tag_q[i] == rs.cdb_tag) rs2_rdy_d[i] = 1'b1;
         end
      end
      if (issue_fire) valid_d[issue_idx] = 1'b0;
      if (disp_fire) begin
         valid_d[alloc_idx]   = 1'b1;
         op_d[alloc_idx]      = rs.disp_op;
         rd_tag_d[alloc_idx]  = rs.disp_rd_tag;
         rs1_tag_d[alloc_idx] = rs.disp_rs1_tag;
         rs2_tag_d[alloc_idx] = rs.disp_rs2_tag;
         rs1_rdy_d[alloc_idx] = rs.disp_rs1_rdy |
                                (rs.cdb_valid && rs.cdb_tag == rs.disp_rs1_tag);
         rs2_rdy_d[alloc_idx] = rs.disp_rs2_rdy |
                                (rs.cdb_valid && rs.cdb_tag == rs.disp_rs2_tag);
      end
      if (rs.flush) valid_d = '0;
   end

   // Control state: valid and readiness bits, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= '0;
         rs1_rdy_q <= '0;
         rs2_rdy_q <= '0;
      end else begin
         valid_q   <= valid_d;
         rs1_rdy_q <= rs1_rdy_d;
         rs2_rdy_q <= rs2_rdy_d;
      end
   end

   // Payload and tags: only meaningful while valid, so they carry no reset
   always_ff @(posedge clk) begin
      op_q      <= op_d;
      rd_tag_q  <= rd_tag_d;
      rs1_tag_q <= rs1_tag_d;
      rs2_tag_q <= rs2_tag_d;
   end

`ifdef RS_OCC_COUNT_EN
   logic [IDX_W:0] occ_q, occ_d;

   // Occupancy tracks dispatch/issue fires; simultaneous fires cancel
   always_comb begin
      occ_d = occ_q;
      if (rs.flush)                    occ_d = '0;
      else if (disp_fire && !issue_fire) occ_d = occ_q + (IDX_W+1)'(1);
      else if (issue_fire && !disp_fire) occ_d = occ_q - (IDX_W+1)'(1);
   end

   // Occupancy register
   always_ff @(posedge clk) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_d;
   end

   assign occupancy = occ_q;
`endif
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: vector table, directed multi-cycle sequences,
// and randomized traffic against an entry-list reference model.
module tb_reservation_station;
   localparam int DEPTH = 8;
   localparam int TAG_W = 6;
   localparam int OP_W  = 32;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   reservation_station_if #(.TAG_W(TAG_W), .OP_W(OP_W)) bus ();

`ifdef RS_OCC_COUNT_EN
   logic [$clog2(DEPTH):0] occupancy;
`endif

   reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .rs        (bus)
`ifdef RS_OCC_COUNT_EN
      ,
      .occupancy (occupancy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int dv, op, rd, s1, s2, r1, r2, cv, ct, ir, fl;
      int e_dr, e_iv, e_op, e_occ;
   } vec_t;

   typedef struct {
      bit v;
      int op, rd, s1, s2;
      bit r1, r2;
   } ent_t;

   ent_t m [DEPTH];
   int   m_occ;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_occ(input string nm, input int exp);
`ifdef RS_OCC_COUNT_EN
      chk(nm, 32'(occupancy), exp);
`endif
   endtask

   task automatic drv(input int dv, op, rd, s1, s2, r1, r2, cv, ct, ir, fl);
      bus.disp_valid   = dv[0];
      bus.disp_op      = op;
      bus.disp_rd_tag  = rd[TAG_W-1:0];
      bus.disp_rs1_tag = s1[TAG_W-1:0];
      bus.disp_rs2_tag = s2[TAG_W-1:0];
      bus.disp_rs1_rdy = r1[0];
      bus.disp_rs2_rdy = r2[0];
      bus.cdb_valid    = cv[0];
      bus.cdb_tag      = ct[TAG_W-1:0];
      bus.issue_ready  = ir[0];
      bus.flush        = fl[0];
   endtask

   task automatic idle(input int ir);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, ir, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      idle(0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      m_occ = 0;
   endtask

   function automatic int hi_free();
      int r = -1;
      for (int i = 0; i < DEPTH; i++) if (!m[i].v) r = i;
      return r;
   endfunction

   function automatic int hi_ready();
      int r = -1;
      for (int i = 0; i < DEPTH; i++) if (m[i].v && m[i].r1 && m[i].r2) r = i;
      return r;
   endfunction

   vec_t tbl [8];

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      idle(0);

      //           dv op     rd s1 s2 r1 r2 cv ct ir fl  dr iv op    occ
      tbl[0] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,    0};
      tbl[1] = '{1, 'hA,   3, 1, 2, 1, 1, 0, 0, 1, 0,  1, 0, 0,    0};
      tbl[2] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 'hA,  1};
      tbl[3] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0,    0};
      tbl[4] = '{1, 'hB,   4, 1, 9, 1, 0, 1, 9, 0, 0,  1, 0, 0,    0};
      tbl[5] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 'hB,  1};
      tbl[6] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 1, 'hB,  1};
      tbl[7] = '{0, 0,     0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0,    0};

      reset_dut();
      for (int i = 0; i < 8; i++) begin
         drv(tbl[i].dv, tbl[i].op, tbl[i].rd, tbl[i].s1, tbl[i].s2, tbl[i].r1,
             tbl[i].r2, tbl[i].cv, tbl[i].ct, tbl[i].ir, tbl[i].fl);
         #1;
         chk($sformatf("vec%0d_disp_ready", i), 32'(bus.disp_ready), tbl[i].e_dr);
         chk($sformatf("vec%0d_issue_valid", i), 32'(bus.issue_valid), tbl[i].e_iv);
         if (tbl[i].e_iv != 0)
            chk($sformatf("vec%0d_issue_op", i), bus.issue_op, tbl[i].e_op);
         chk_occ($sformatf("vec%0d_occupancy", i), tbl[i].e_occ);
         tick();
      end

      // Fill with waiting entries, wake all with one broadcast, drain 7..0
      reset_dut();
      for (int j = 0; j < 8; j++) begin
         drv(1, 'h100 + j, 16 + j, 5, 0, 0, 1, 0, 0, 1, 0);
         #1;
         chk("fill_disp_ready", 32'(bus.disp_ready), 1);
         chk("fill_issue_valid", 32'(bus.issue_valid), 0);
         tick();
      end
      idle(1);
      #1;
      chk("full_disp_ready", 32'(bus.disp_ready), 0);
      chk("full_issue_valid", 32'(bus.issue_valid), 0);
      chk_occ("full_occupancy", 8);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0);
      #1;
      chk("wake_cycle_issue_valid", 32'(bus.issue_valid), 0);
      tick();
      for (int k = 0; k < 8; k++) begin
         idle(1);
         #1;
         chk($sformatf("drain%0d_issue_valid", k), 32'(bus.issue_valid), 1);
         chk($sformatf("drain%0d_rd_tag", k), 32'(bus.issue_rd_tag), 16 + k);
         tick();
      end
      idle(1);
      #1;
      chk("drained_issue_valid", 32'(bus.issue_valid), 0);
      chk("drained_disp_ready", 32'(bus.disp_ready), 1);
      tick();

      // Full queue: issue and dispatch in the same cycle; dispatch refused, lands next cycle
      reset_dut();
      for (int j = 0; j < 8; j++) begin
         drv(1, 'h200 + j, 32 + j, 1, 2, 1, 1, 0, 0, 0, 0);
         tick();
      end
      drv(1, 'h77, 50, 60, 60, 0, 0, 0, 0, 1, 0);
      #1;
      chk("full_iss_disp_ready", 32'(bus.disp_ready), 0);
      chk("full_iss_issue_valid", 32'(bus.issue_valid), 1);
      chk("full_iss_rd_tag", 32'(bus.issue_rd_tag), 32);
      tick();
      drv(1, 'h77, 50, 60, 60, 0, 0, 0, 0, 0, 0);
      #1;
      chk("freed_disp_ready", 32'(bus.disp_ready), 1);
      chk_occ("freed_occupancy", 7);
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 1, 60, 0, 0);
      #1;
      chk("refull_disp_ready", 32'(bus.disp_ready), 0);
      chk("refull_rd_tag", 32'(bus.issue_rd_tag), 33);
      chk_occ("refull_occupancy", 8);
      tick();
      idle(0);
      #1;
      chk("landed_rd_tag", 32'(bus.issue_rd_tag), 50);
      chk("landed_op", bus.issue_op, 'h77);
      tick();

      // Flush with 4 valid entries plus dispatch and issue requests
      reset_dut();
      for (int j = 0; j < 4; j++) begin
         drv(1, 'h400 + j, 40 + j, 0, 0, 1, 1, 0, 0, 0, 0);
         tick();
      end
      drv(1, 'h99, 45, 0, 0, 1, 1, 0, 0, 1, 1);
      #1;
      chk("flush_cycle_issue_valid", 32'(bus.issue_valid), 0);
      tick();
      idle(1);
      #1;
      chk("post_flush_issue_valid", 32'(bus.issue_valid), 0);
      chk("post_flush_disp_ready", 32'(bus.disp_ready), 1);
      chk_occ("post_flush_occupancy", 0);
      tick();

      // Preemption: entry 2 presented, entry 6 wakes and takes over
      reset_dut();
      for (int j = 0; j < 6; j++) begin
         drv(1, 'h300 + j, j + 1, 30 + j, 0, (j == 5) ? 1 : 0, 1, 0, 0, 0, 0);
         tick();
      end
      idle(0);
      #1;
      chk("pre_issue_valid", 32'(bus.issue_valid), 1);
      chk("pre_rd_tag", 32'(bus.issue_rd_tag), 6);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 31, 0, 0);
      #1;
      chk("pre_wake_rd_tag", 32'(bus.issue_rd_tag), 6);
      tick();
      idle(0);
      #1;
      chk("preempt_rd_tag", 32'(bus.issue_rd_tag), 2);
      tick();
      idle(1);
      #1;
      chk("preempt_issue_rd_tag", 32'(bus.issue_rd_tag), 2);
      tick();
      idle(1);
      #1;
      chk("entry2_kept_valid", 32'(bus.issue_valid), 1);
      chk("entry2_kept_rd_tag", 32'(bus.issue_rd_tag), 6);
      tick();

      // Randomized traffic against the reference model
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         int dv, op, rd, s1, s2, r1, r2, cv, ct, ir, fl;
         int sel, alloc;
         bit e_dr, e_iv, dfire, ifire;
         dv = ($urandom_range(0, 9) < 6) ? 1 : 0;
         op = int'($urandom);
         rd = int'($urandom_range(0, 63));
         s1 = int'($urandom_range(0, 7));
         s2 = int'($urandom_range(0, 7));
         r1 = int'($urandom_range(0, 1));
         r2 = int'($urandom_range(0, 1));
         cv = int'($urandom_range(0, 1));
         ct = int'($urandom_range(0, 7));
         ir = int'($urandom_range(0, 1));
         fl = ($urandom_range(0, 99) < 2) ? 1 : 0;
         drv(dv, op, rd, s1, s2, r1, r2, cv, ct, ir, fl);
         #1;
         alloc = hi_free();
         sel   = hi_ready();
         e_dr  = (alloc >= 0);
         e_iv  = (sel >= 0) && (fl == 0);
         chk("rnd_disp_ready", 32'(bus.disp_ready), 32'(e_dr));
         chk("rnd_issue_valid", 32'(bus.issue_valid), 32'(e_iv));
         if (e_iv) begin
            chk("rnd_issue_op", bus.issue_op, m[sel].op);
            chk("rnd_issue_rd_tag", 32'(bus.issue_rd_tag), m[sel].rd);
            chk("rnd_issue_rs1_tag", 32'(bus.issue_rs1_tag), m[sel].s1);
            chk("rnd_issue_rs2_tag", 32'(bus.issue_rs2_tag), m[sel].s2);
         end
         chk_occ("rnd_occupancy", m_occ);
         dfire = (dv != 0) && e_dr && (fl == 0);
         ifire = e_iv && (ir != 0);
         if (fl != 0) begin
            for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
            m_occ = 0;
         end else begin
            if (cv != 0)
               for (int i = 0; i < DEPTH; i++) begin
                  if (m[i].s1 == ct) m[i].r1 = 1'b1;
                  if (m[i].s2 == ct) m[i].r2 = 1'b1;
               end
            if (ifire) begin
               m[sel].v = 1'b0;
               m_occ--;
            end
            if (dfire) begin
               m[alloc].v  = 1'b1;
               m[alloc].op = op;
               m[alloc].rd = rd;
               m[alloc].s1 = s1;
               m[alloc].s2 = s2;
               m[alloc].r1 = (r1 != 0) || (cv != 0 && ct == s1);
               m[alloc].r2 = (r2 != 0) || (cv != 0 && ct == s2);
               m_occ++;
            end
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
# reservation_station

Unified issue queue between rename/dispatch and the functional units. It holds up to DEPTH renamed micro-ops and tracks operand readiness from common data bus (CDB) tag broadcasts. Each cycle it presents one ready micro-op to the downstream functional unit. Entry allocation and issue selection both use highest-index-first priority over per-entry bit vectors.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2
- TAG_W, 6: physical register tag width
- OP_W, 32: opaque micro-op payload width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  squash all entries (branch mispredict)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_op  in  OP_W  micro-op payload
- disp_rd_tag  in  TAG_W  destination tag
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  source tags
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  source already available at dispatch
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  tag being written back
- issue_valid  out  1  a ready entry is presented
- issue_ready  in  1  functional unit accepts
- issue_op  out  OP_W  payload of selected entry
- issue_rd_tag, issue_rs1_tag, issue_rs2_tag  out  TAG_W each  tags of selected entry
- occupancy  out  $clog2(DEPTH)+1  valid entry count (only with RS_OCC_COUNT_EN)

## Operation
- Per-entry state: valid, op, rd_tag, rs1/rs2 tag, rs1/rs2 rdy.
- free = ~valid. The selected allocation index is the highest set bit of free.
- req[i] = valid[i] & rs1_rdy[i] & rs2_rdy[i]. The selected issue index is the highest set bit of req. There is no age ordering.
- Dispatch fires on disp_valid & disp_ready & ~flush. The entry is written at the allocation index with valid=1.
- Dispatch/CDB bypass: if cdb_valid and cdb_tag equals a dispatching source tag, that source is written with rdy=1.
- Wakeup: for every valid entry with a waiting source whose tag equals cdb_tag while cdb_valid is high, that source's rdy is set at the edge. Multiple entries and both sources may wake in the same cycle.
- Issue fires on issue_valid & issue_ready. The selected entry's valid is cleared at the edge.
- The issue_* outputs are combinational from registered entry state and the selection. Their values are don't-care when issue_valid=0.
- Flush: all valid bits are cleared at the edge. Dispatch and issue in the flush cycle are dropped.
- Reset takes precedence over flush, and flush over dispatch, issue and wakeup.

## Timing
- Reset values: all valid=0, disp_ready=1, issue_valid=0, occupancy=0.
- disp_ready = ~&valid (registered state only). A slot freed by an issue this cycle is usable next cycle.
- issue_valid = |req & ~flush.
- Dispatch-to-issue latency:
  - Both sources ready at dispatch: 1 cycle (issue_valid in the cycle after dispatch).
  - Woken source: issuable the cycle after the CDB broadcast.
- issue_valid and the presented entry may change while issue_ready=0. A higher-index entry becoming ready preempts the presented one.
- Simultaneous dispatch and issue: both occur; occupancy is unchanged.
- A CDB broadcast in the issue cycle of an entry has no effect on that entry.
- Full (DEPTH valid): disp_ready=0; disp_valid is ignored.
- Empty: issue_valid=0.

## Configuration
- RS_OCC_COUNT_EN defined:
  - Port occupancy exists.
  - occupancy is a registered counter: +1 on dispatch fire, -1 on issue fire, net 0 on both, 0 on reset/flush.
- RS_OCC_COUNT_EN undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then dispatch op=0xA, rs1_rdy=rs2_rdy=1, issue_ready=1 -> entry 7 allocated; next cycle issue_valid=1, issue_op=0xA; the following cycle issue_valid=0, disp_ready=1.
- Fill 8 entries with rs1_tag=5 not ready, issue_ready=1 -> disp_ready=0 after the 8th, issue_valid=0. Then cdb_valid=1, cdb_tag=5 -> next cycle issue_valid=1, entries issue 7,6,…,0 on consecutive cycles.
- Dispatch rs2_tag=9 not ready with cdb_valid=1, cdb_tag=9 in the same cycle -> bypass; issue_valid=1 the next cycle.
- Full queue, issue_ready=1 and disp_valid=1 in the same cycle -> disp_ready=0 that cycle, so the dispatch is not accepted. Next cycle disp_ready=1; the dispatch then lands in the freed index.
- 4 valid entries, flush=1 with disp_valid=1 and issue_ready=1 -> next cycle all entries invalid, issue_valid=0, no issue fire, occupancy=0 (with RS_OCC_COUNT_EN).
- Entry ready at index 2 held with issue_ready=0; index 6 becomes ready -> issue_rd_tag switches to entry 6's tag; entry 2 remains valid.
